ideal_mem_responder: RTL and testbench
======================================

IDEAL_MEM_RESPONDER -- requirements
Module: ideal_mem_responder

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- ADDR_WIDTH, 12, word-address bits of internal RAM (2^ADDR_WIDTH 32-bit words)
- LATENCY, 2, cycles from request acceptance to first response-valid cycle (legal 1..15)
REQ-002 SHALL have ports, one per line: name direction width meaning:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- PC  in  32  instruction fetch byte address
- Inst_Req_Valid  in  1  fetch request valid
- Inst_Req_Ready  out  1  fetch request accepted when high with Inst_Req_Valid
- Instruction  out  32  fetched word
- Inst_Valid  out  1  Instruction valid
- Inst_Ready  in  1  initiator accepts Instruction
- Address  in  32  data byte address
- MemWrite  in  1  data write request
- Write_data  in  32  write data
- Write_strb  in  4  byte enables, bit i = byte lane i
- MemRead  in  1  data read request
- Mem_Req_Ready  out  1  data request accepted when high with MemRead or MemWrite
- Read_data  out  32  read word
- Read_data_Valid  out  1  Read_data valid
- Read_data_Ready  in  1  initiator accepts Read_data
REQ-003 Clock and reset SHALL be exactly as decided: one clock; reset is synchronous and active-high.

Function
REQ-004 Word index SHALL be addr[ADDR_WIDTH+1:2]; addr[1:0] and bits above ADDR_WIDTH+1 ignored (aliasing/wrap-around).
REQ-005 Instruction FSM SHALL have states I_IDLE, I_WAIT, I_RESP; data FSM SHALL have D_IDLE, D_WAIT, D_RESP.
REQ-006 Mem_Req_Ready SHALL equal (data state == D_IDLE).
REQ-007 Inst_Req_Ready SHALL equal (inst state == I_IDLE) AND NOT (data state == D_IDLE AND (MemRead OR MemWrite)); data wins simultaneous requests.
REQ-008 Acceptance cycle c: RAM read SHALL occur in c and the word SHALL be captured at the end of c; contents later written do not affect it.
REQ-009 Read response valid SHALL first assert in cycle c+LATENCY; LATENCY=1 goes IDLE->RESP directly, else IDLE->WAIT with a down-counter, WAIT->RESP when it expires.
REQ-010 In RESP, valid SHALL stay high and data stable until valid&ready; then return to IDLE next cycle; no new request accepted in same cycle.
REQ-011 Write accepted (MemWrite & Mem_Req_Ready) SHALL update only lanes with Write_strb[i]=1 at end of c; data FSM stays D_IDLE; no response generated.
REQ-012 MemRead and MemWrite both high SHALL be treated as write only.
REQ-013 Write_strb=0000 write SHALL be accepted and leave RAM unchanged.
REQ-014 Inst_Ready/Read_data_Ready high outside RESP SHALL be ignored.
REQ-015 Both FSMs SHALL operate concurrently; instruction response backpressure SHALL NOT block data requests and vice versa.

Reset
REQ-016 While rst=1: both FSMs to IDLE, counters 0, Inst_Valid=0, Read_data_Valid=0, Instruction=0, Read_data=0, Inst_Req_Ready=0, Mem_Req_Ready=0.
REQ-017 Reset mid-WAIT/RESP SHALL abort the transaction without emitting any response; readies high first cycle after rst deasserts.
REQ-018 RAM contents SHALL NOT be reset.

Verification (LATENCY=2, ADDR_WIDTH=12)
REQ-019 Write 0xDEADBEEF, strb 1111 @0x10; MemRead @0x10 accepted cycle c -> Read_data_Valid=1 in c+2, Read_data=0xDEADBEEF.
REQ-020 Word @0x14=0x11223344; write 0x0000AB00 strb 0010 -> read returns 0x1122AB44.
REQ-021 Same cycle Inst_Req_Valid PC=0x10 and MemRead @0x20 -> Mem_Req_Ready=1, Inst_Req_Ready=0; fetch accepted next cycle, Inst_Valid 2 cycles later with word @0x10.
REQ-022 Read_data_Ready low 5 cycles during RESP -> Read_data_Valid and Read_data stable, Mem_Req_Ready=0 throughout; fetches still serviced.
REQ-023 rst pulsed in I_WAIT -> Inst_Valid never asserts; Inst_Req_Ready=1 first cycle after rst low.
REQ-024 Write 0xCAFEF00D @0x4010 -> fetch PC=0x0010 returns 0xCAFEF00D.

Source files
------------

// File: rtl/ideal_mem_responder_if.sv
// Fetch and load/store handshake bundle between a core and its memory responder.
// The master drives requests and response-ready; the slave returns request-ready and responses.
interface ideal_mem_responder_if;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  modport master (
    output PC, Inst_Req_Valid, Inst_Ready,
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    input  Inst_Req_Ready, Instruction, Inst_Valid,
    input  Mem_Req_Ready, Read_data, Read_data_Valid
  );

  modport slave (
    input  PC, Inst_Req_Valid, Inst_Ready,
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    output Inst_Req_Ready, Instruction, Inst_Valid,
    output Mem_Req_Ready, Read_data, Read_data_Valid
  );
endinterface

// File: rtl/ideal_mem_responder.sv
// Single-RAM ideal memory with independent fetch and data ports; reads answer LATENCY
// cycles after acceptance and hold until taken, writes complete in the acceptance cycle.
module ideal_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ideal_mem_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] I_IDLE = 2'd0;
  localparam logic [1:0] I_WAIT = 2'd1;
  localparam logic [1:0] I_RESP = 2'd2;

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_WAIT = 2'd1;
  localparam logic [1:0] D_RESP = 2'd2;

  // WAIT is occupied LATENCY-1 cycles; the counter expires when it reads zero.
  localparam bit         DIRECT   = (LATENCY == 1);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] i_idx;
  logic [ADDR_WIDTH-1:0] d_idx;

  logic [1:0]  i_state_q, i_state_d;
  logic [3:0]  i_cnt_q,   i_cnt_d;
  logic [31:0] inst_dat_q, inst_dat_d;

  logic [1:0]  d_state_q, d_state_d;
  logic [3:0]  d_cnt_q,   d_cnt_d;
  logic [31:0] rd_dat_q,  rd_dat_d;

  logic d_req;
  logic mem_req_rdy;
  logic inst_req_rdy;
  logic d_wr_en;
  logic d_rd_acc;
  logic i_acc;

  logic unused_addr_bits;

  assign i_idx = bus.PC[ADDR_WIDTH+1:2];
  assign d_idx = bus.Address[ADDR_WIDTH+1:2];

  // Upper and byte-offset address bits alias onto the same word by design.
  assign unused_addr_bits = ^{bus.PC[31:ADDR_WIDTH+2], bus.PC[1:0],
                              bus.Address[31:ADDR_WIDTH+2], bus.Address[1:0]};

  // Data port has priority: a pending data request in D_IDLE holds off the fetch port.
  assign d_req        = bus.MemRead | bus.MemWrite;
  assign mem_req_rdy  = !rst && (d_state_q == D_IDLE);
  assign inst_req_rdy = !rst && (i_state_q == I_IDLE) && !((d_state_q == D_IDLE) && d_req);

  assign d_wr_en  = bus.MemWrite && mem_req_rdy;
  assign d_rd_acc = bus.MemRead && !bus.MemWrite && mem_req_rdy;
  assign i_acc    = bus.Inst_Req_Valid && inst_req_rdy;

  always_comb begin
    i_state_d  = i_state_q;
    i_cnt_d    = i_cnt_q;
    inst_dat_d = inst_dat_q;
    case (i_state_q)
      I_IDLE: begin
        if (i_acc) begin
          inst_dat_d = mem[i_idx];
          if (DIRECT) begin
            i_state_d = I_RESP;
          end else begin
            i_state_d = I_WAIT;
            i_cnt_d   = CNT_LOAD;
          end
        end
      end
      I_WAIT: begin
        if (i_cnt_q == 4'd0) begin
          i_state_d = I_RESP;
        end else begin
          i_cnt_d = i_cnt_q - 4'd1;
        end
      end
      I_RESP: begin
        if (bus.Inst_Ready) begin
          i_state_d = I_IDLE;
        end
      end
      default: i_state_d = I_IDLE;
    endcase
  end

  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    rd_dat_d  = rd_dat_q;
    case (d_state_q)
      D_IDLE: begin
        if (d_rd_acc) begin
          rd_dat_d = mem[d_idx];
          if (DIRECT) begin
            d_state_d = D_RESP;
          end else begin
            d_state_d = D_WAIT;
            d_cnt_d   = CNT_LOAD;
          end
        end
      end
      D_WAIT: begin
        if (d_cnt_q == 4'd0) begin
          d_state_d = D_RESP;
        end else begin
          d_cnt_d = d_cnt_q - 4'd1;
        end
      end
      D_RESP: begin
        if (bus.Read_data_Ready) begin
          d_state_d = D_IDLE;
        end
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_state_q  <= I_IDLE;
      i_cnt_q    <= 4'd0;
      inst_dat_q <= 32'd0;
      d_state_q  <= D_IDLE;
      d_cnt_q    <= 4'd0;
      rd_dat_q   <= 32'd0;
    end else begin
      i_state_q  <= i_state_d;
      i_cnt_q    <= i_cnt_d;
      inst_dat_q <= inst_dat_d;
      d_state_q  <= d_state_d;
      d_cnt_q    <= d_cnt_d;
      rd_dat_q   <= rd_dat_d;
    end
  end

  // RAM keeps its contents across reset; d_wr_en is already blocked while rst is high.
  always_ff @(posedge clk) begin
    if (d_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.Write_strb[i]) begin
          mem[d_idx][8*i +: 8] <= bus.Write_data[8*i +: 8];
        end
      end
    end
  end

  // Outputs are forced quiet combinationally so they read zero during every reset cycle.
  assign bus.Mem_Req_Ready   = mem_req_rdy;
  assign bus.Inst_Req_Ready  = inst_req_rdy;
  assign bus.Inst_Valid      = !rst && (i_state_q == I_RESP);
  assign bus.Instruction     = rst ? 32'd0 : inst_dat_q;
  assign bus.Read_data_Valid = !rst && (d_state_q == D_RESP);
  assign bus.Read_data       = rst ? 32'd0 : rd_dat_q;

endmodule

// File: tb/tb_ideal_mem_responder.sv
// Directed plus randomized bench for ideal_mem_responder at ADDR_WIDTH=12, LATENCY=2,
// checked against a word-array model of the RAM.
module tb_ideal_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ideal_mem_responder_if bus ();

  ideal_mem_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [4096];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd4096);
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic mem_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic with_read);
    bus.Address    = a;
    bus.Write_data = d;
    bus.Write_strb = s;
    bus.MemWrite   = 1'b1;
    bus.MemRead    = with_read;
    @(negedge clk);
    check("wr_req_rdy", 32'(bus.Mem_Req_Ready), 32'd1);
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    for (int i = 0; i < 4; i++)
      if (s[i]) ref_mem[widx(a)][8*i +: 8] = d[8*i +: 8];
    @(negedge clk);
    check("wr_no_resp", 32'(bus.Read_data_Valid), 32'd0);
    check("wr_still_idle", 32'(bus.Mem_Req_Ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic mem_read(input logic [31:0] a);
    logic [31:0] exp;
    int n;
    exp = ref_mem[widx(a)];
    bus.Address         = a;
    bus.MemRead         = 1'b1;
    bus.Read_data_Ready = 1'b0;
    @(negedge clk);
    check("rd_req_rdy", 32'(bus.Mem_Req_Ready), 32'd1);
    @(posedge clk);
    #1;
    bus.MemRead = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.Read_data_Valid && n < 16);
    check("rd_latency", 32'(n), 32'd2);
    check("rd_data", bus.Read_data, exp);
    bus.Read_data_Ready = 1'b1;
    @(posedge clk);
    #1;
    bus.Read_data_Ready = 1'b0;
    @(negedge clk);
    check("rd_done", 32'(bus.Read_data_Valid), 32'd0);
    check("rd_idle", 32'(bus.Mem_Req_Ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    logic [31:0] exp;
    int n;
    exp = ref_mem[widx(pc)];
    bus.PC             = pc;
    bus.Inst_Req_Valid = 1'b1;
    bus.Inst_Ready     = 1'b0;
    @(negedge clk);
    check("if_req_rdy", 32'(bus.Inst_Req_Ready), 32'd1);
    @(posedge clk);
    #1;
    bus.Inst_Req_Valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.Inst_Valid && n < 16);
    check("if_latency", 32'(n), 32'd2);
    check("if_data", bus.Instruction, exp);
    bus.Inst_Ready = 1'b1;
    @(posedge clk);
    #1;
    bus.Inst_Ready = 1'b0;
    @(negedge clk);
    check("if_done", 32'(bus.Inst_Valid), 32'd0);
    check("if_idle", 32'(bus.Inst_Req_Ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_d, exp_i, a;
    int          words [8];
    int          p, op;

    bus.PC = '0; bus.Inst_Req_Valid = 1'b0; bus.Inst_Ready = 1'b0;
    bus.Address = '0; bus.MemWrite = 1'b0; bus.Write_data = '0; bus.Write_strb = '0;
    bus.MemRead = 1'b0; bus.Read_data_Ready = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_inst_valid", 32'(bus.Inst_Valid), 32'd0);
    check("rst_rd_valid", 32'(bus.Read_data_Valid), 32'd0);
    check("rst_instruction", bus.Instruction, 32'd0);
    check("rst_read_data", bus.Read_data, 32'd0);
    check("rst_inst_req_rdy", 32'(bus.Inst_Req_Ready), 32'd0);
    check("rst_mem_req_rdy", 32'(bus.Mem_Req_Ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_inst_rdy", 32'(bus.Inst_Req_Ready), 32'd1);
    check("post_rst_mem_rdy", 32'(bus.Mem_Req_Ready), 32'd1);
    @(posedge clk);
    #1;

    // Full-word write then read back
    mem_write(32'h10, 32'hDEADBEEF, 4'b1111, 1'b0);
    mem_read(32'h10);

    // Byte-lane merge, then an all-zero strobe that must change nothing
    mem_write(32'h14, 32'h11223344, 4'b1111, 1'b0);
    mem_write(32'h14, 32'h0000AB00, 4'b0010, 1'b0);
    mem_read(32'h14);
    mem_write(32'h14, 32'hFFFFFFFF, 4'b0000, 1'b0);
    mem_read(32'h14);

    // Read and write together acts as a write only
    mem_write(32'h20, $urandom, 4'b1111, 1'b1);

    // Simultaneous fetch and data read: data wins, fetch follows a cycle later
    exp_d = ref_mem[widx(32'h20)];
    exp_i = ref_mem[widx(32'h10)];
    bus.PC = 32'h10; bus.Inst_Req_Valid = 1'b1;
    bus.Address = 32'h20; bus.MemRead = 1'b1;
    @(negedge clk);
    check("arb_mem_rdy", 32'(bus.Mem_Req_Ready), 32'd1);
    check("arb_inst_blocked", 32'(bus.Inst_Req_Ready), 32'd0);
    @(posedge clk);
    #1;
    bus.MemRead = 1'b0;
    @(negedge clk);
    check("arb_inst_rdy_next", 32'(bus.Inst_Req_Ready), 32'd1);
    check("arb_rd_not_yet", 32'(bus.Read_data_Valid), 32'd0);
    @(posedge clk);
    #1;
    bus.Inst_Req_Valid = 1'b0;
    @(negedge clk);
    check("arb_rd_valid", 32'(bus.Read_data_Valid), 32'd1);
    check("arb_rd_data", bus.Read_data, exp_d);
    check("arb_inst_not_yet", 32'(bus.Inst_Valid), 32'd0);
    @(negedge clk);
    check("arb_inst_valid", 32'(bus.Inst_Valid), 32'd1);
    check("arb_inst_data", bus.Instruction, exp_i);
    bus.Read_data_Ready = 1'b1;
    bus.Inst_Ready = 1'b1;
    @(posedge clk);
    #1;
    bus.Read_data_Ready = 1'b0;
    bus.Inst_Ready = 1'b0;
    @(negedge clk);
    check("arb_rd_drop", 32'(bus.Read_data_Valid), 32'd0);
    check("arb_inst_drop", 32'(bus.Inst_Valid), 32'd0);
    @(posedge clk);
    #1;

    // Data response held for five cycles while a fetch completes alongside
    exp_d = ref_mem[widx(32'h14)];
    exp_i = ref_mem[widx(32'h10)];
    bus.Address = 32'h14; bus.MemRead = 1'b1;
    @(posedge clk);
    #1;
    bus.MemRead = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_rd_valid", 32'(bus.Read_data_Valid), 32'd1);
      check("bp_rd_data", bus.Read_data, exp_d);
      check("bp_mem_rdy_low", 32'(bus.Mem_Req_Ready), 32'd0);
      if (k == 0) begin
        check("bp_inst_rdy", 32'(bus.Inst_Req_Ready), 32'd1);
        bus.PC = 32'h10; bus.Inst_Req_Valid = 1'b1; bus.Inst_Ready = 1'b1;
        @(posedge clk);
        #1;
        bus.Inst_Req_Valid = 1'b0;
      end
      if (k == 2) begin
        check("bp_inst_valid", 32'(bus.Inst_Valid), 32'd1);
        check("bp_inst_data", bus.Instruction, exp_i);
      end
      if (k == 3) check("bp_inst_taken", 32'(bus.Inst_Valid), 32'd0);
    end
    bus.Inst_Ready = 1'b0;
    bus.Read_data_Ready = 1'b1;
    @(posedge clk);
    #1;
    bus.Read_data_Ready = 1'b0;
    @(negedge clk);
    check("bp_rd_drop", 32'(bus.Read_data_Valid), 32'd0);
    check("bp_mem_rdy_back", 32'(bus.Mem_Req_Ready), 32'd1);
    @(posedge clk);
    #1;

    // Reset pulse while a fetch is waiting must swallow its response
    bus.PC = 32'h14; bus.Inst_Req_Valid = 1'b1; bus.Inst_Ready = 1'b1;
    @(posedge clk);
    #1;
    bus.Inst_Req_Valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw_inst_rdy_low", 32'(bus.Inst_Req_Ready), 32'd0);
    check("rstw_mem_rdy_low", 32'(bus.Mem_Req_Ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstw_no_inst_valid", 32'(bus.Inst_Valid), 32'd0);
      if (k == 0) check("rstw_inst_rdy", 32'(bus.Inst_Req_Ready), 32'd1);
    end
    bus.Inst_Ready = 1'b0;
    @(posedge clk);
    #1;

    // Address aliasing: 0x4010 and 0x0010 share a word
    mem_write(32'h4010, 32'hCAFEF00D, 4'b1111, 1'b0);
    fetch(32'h0010);

    // Randomized traffic against the array model
    for (int i = 0; i < 8; i++) begin
      words[i] = int'($urandom_range(64, 4095));
      mem_write(32'(words[i]) << 2, $urandom, 4'b1111, 1'b0);
    end
    for (int j = 0; j < 24; j++) begin
      p  = words[$urandom_range(0, 7)];
      a  = (32'(p) << 2) | ($urandom & 32'hFFFF_C003);
      op = int'($urandom_range(0, 2));
      case (op)
        0:       mem_write(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        1:       mem_read(a);
        default: fetch(a);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
